emu_pll_ctrl: RTL and testbench

EMU_PLL_CTRL -- requirements
Module: emu_pll_ctrl

---
 rtl/emu_pll_ctrl_pkg.sv | 25 ++
 rtl/prim_flop_2sync.sv | 31 +++
 rtl/emu_pll_ctrl.sv | 156 +++++++++++++++
 tb/tb_emu_pll_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/emu_pll_ctrl_pkg.sv
// Package for the PLL power/ratio controller.
// Holds the FSM state encoding, the default parameter values and a small
// helper that classifies a requested ratio.
package emu_pll_ctrl_pkg;

    typedef enum logic [2:0] {
        StOff      = 3'd0,
        StLockWait = 3'd1,
        StLocked   = 3'd2,
        StGate     = 3'd3,
        StSettle   = 3'd4,
        StFault    = 3'd5
    } pll_state_e;

    localparam logic [31:0] DefLockTimeout  = 32'd4096;
    localparam logic [15:0] DefSettleCycles = 16'd8;
    localparam logic [31:0] DefRstNum       = 32'h1;
    localparam logic [31:0] DefRstDen       = 32'h1;

    // A ratio with a zero term would stall or break the PLL divider.
    function automatic logic ratio_ok(input logic [31:0] num, input logic [31:0] den);
        return (num != 32'd0) && (den != 32'd0);
    endfunction

endpackage

// File: rtl/prim_flop_2sync.sv
// Two-flop synchroniser for signals arriving asynchronously to clk_i.
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset, both stages clear to 0
//   d_i    - asynchronous input
//   q_o    - synchronised output, two clk_i edges of latency
module prim_flop_2sync #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/emu_pll_ctrl.sv
// PLL power-up, lock supervision and ratio-change controller.
// Ports:
//   clk_i, rst_ni             - reference clock, asynchronous active-low reset
//   pwr_req_i                 - level request to run the PLL
//   cfg_valid_i/num_i/den_i   - ratio change request
//   cfg_ready_o               - request accepted this cycle (OFF and LOCKED only)
//   cfg_err_o                 - same-cycle pulse: accepted request had a zero term
//   pll_lock_i                - raw PLL lock, asynchronous
//   pll_en_o, pll_num_o/den_o - PLL enable and ratio
//   locked_o                  - downstream clock-gate enable
//   lock_lost_o               - one-cycle pulse on unexpected lock loss
//   timeout_o                 - high while parked in FAULT after a lock timeout
//   state_o                   - current FSM state
module emu_pll_ctrl
    import emu_pll_ctrl_pkg::*;
#(
    parameter logic [31:0] LOCK_TIMEOUT  = DefLockTimeout,
    parameter logic [15:0] SETTLE_CYCLES = DefSettleCycles,
    parameter logic [31:0] RST_NUM       = DefRstNum,
    parameter logic [31:0] RST_DEN       = DefRstDen
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pwr_req_i,
    input  logic        cfg_valid_i,
    input  logic [31:0] cfg_num_i,
    input  logic [31:0] cfg_den_i,
    output logic        cfg_ready_o,
    output logic        cfg_err_o,
    input  logic        pll_lock_i,
    output logic        pll_en_o,
    output logic [31:0] pll_num_o,
    output logic [31:0] pll_den_o,
    output logic        locked_o,
    output logic        lock_lost_o,
    output logic        timeout_o,
    output logic [2:0]  state_o
);

    pll_state_e  state_q;
    logic [31:0] cnt_q;       // lock-wait counter, reused as settle counter
    logic [31:0] num_q, den_q;
    logic [31:0] pend_num_q, pend_den_q;
    logic        pend_q;
    logic        lost_q;
    logic        lock_s;
    logic        cfg_accept;
    logic        cfg_good;

    prim_flop_2sync #(
        .Width (1)
    ) u_lock_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (pll_lock_i),
        .q_o    (lock_s)
    );

    assign cfg_accept = cfg_valid_i && ((state_q == StOff) || (state_q == StLocked));
    assign cfg_good   = cfg_accept && ratio_ok(cfg_num_i, cfg_den_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StOff;
            cnt_q      <= '0;
            num_q      <= RST_NUM;
            den_q      <= RST_DEN;
            pend_num_q <= '0;
            pend_den_q <= '0;
            pend_q     <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            lost_q <= 1'b0;
            unique case (state_q)
                StOff: begin
                    if (cfg_good) begin
                        num_q <= cfg_num_i;
                        den_q <= cfg_den_i;
                    end
                    if (pwr_req_i) begin
                        state_q <= StLockWait;
                        cnt_q   <= '0;
                    end
                end
                StLockWait: begin
                    if (!pwr_req_i) begin
                        state_q <= StOff;
                    end else if (lock_s) begin
                        state_q <= StLocked;
                    end else if (cnt_q == LOCK_TIMEOUT - 32'd1) begin
                        state_q <= StFault;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                StLocked: begin
                    // A ratio accepted together with a power-down is still applied
                    // through SETTLE; one accepted during lock loss is dropped.
                    if (!pwr_req_i) begin
                        state_q <= StGate;
                        if (cfg_good) begin
                            pend_q     <= 1'b1;
                            pend_num_q <= cfg_num_i;
                            pend_den_q <= cfg_den_i;
                        end
                    end else if (!lock_s) begin
                        state_q <= StLockWait;
                        cnt_q   <= '0;
                        lost_q  <= 1'b1;
                    end else if (cfg_good) begin
                        state_q    <= StGate;
                        pend_q     <= 1'b1;
                        pend_num_q <= cfg_num_i;
                        pend_den_q <= cfg_den_i;
                    end
                end
                StGate: begin
                    if (pend_q) begin
                        state_q <= StSettle;
                        cnt_q   <= '0;
                        num_q   <= pend_num_q;
                        den_q   <= pend_den_q;
                        pend_q  <= 1'b0;
                    end else begin
                        state_q <= StOff;
                    end
                end
                StSettle: begin
                    if (cnt_q + 32'd1 >= {16'd0, SETTLE_CYCLES}) begin
                        state_q <= pwr_req_i ? StLockWait : StOff;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                StFault: begin
                    if (!pwr_req_i) begin
                        state_q <= StOff;
                    end
                end
                default: state_q <= StOff;
            endcase
        end
    end

    assign pll_en_o    = (state_q == StLockWait) || (state_q == StLocked) || (state_q == StGate);
    assign locked_o    = (state_q == StLocked);
    assign timeout_o   = (state_q == StFault);
    assign lock_lost_o = lost_q;
    assign cfg_ready_o = cfg_accept;
    assign cfg_err_o   = cfg_accept && !ratio_ok(cfg_num_i, cfg_den_i);
    assign pll_num_o   = num_q;
    assign pll_den_o   = den_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_emu_pll_ctrl.sv
// Self-checking bench for emu_pll_ctrl: directed scenarios plus a randomized
// ratio-change sequence checked against an expected-ratio model.
module tb_emu_pll_ctrl;
    import emu_pll_ctrl_pkg::*;

    localparam logic [31:0] RNum   = 32'h7;
    localparam logic [31:0] RDen   = 32'h3;
    localparam int          Settle = 8;

    logic        clk, rst_n;
    logic        pwr, cfg_valid, lock;
    logic [31:0] cfg_num, cfg_den;
    logic        ready, err, pll_en, locked, lost, tmo;
    logic [31:0] num, den;
    logic [2:0]  st;

    logic        t_pwr, t_ready, t_err, t_en, t_locked, t_lost, t_tmo;
    logic [31:0] t_num, t_den;
    logic [2:0]  t_st;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_num, exp_den;

    emu_pll_ctrl #(
        .LOCK_TIMEOUT  (32'd4096),
        .SETTLE_CYCLES (16'd8),
        .RST_NUM       (RNum),
        .RST_DEN       (RDen)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .pwr_req_i   (pwr),
        .cfg_valid_i (cfg_valid),
        .cfg_num_i   (cfg_num),
        .cfg_den_i   (cfg_den),
        .cfg_ready_o (ready),
        .cfg_err_o   (err),
        .pll_lock_i  (lock),
        .pll_en_o    (pll_en),
        .pll_num_o   (num),
        .pll_den_o   (den),
        .locked_o    (locked),
        .lock_lost_o (lost),
        .timeout_o   (tmo),
        .state_o     (st)
    );

    emu_pll_ctrl #(
        .LOCK_TIMEOUT (32'd16)
    ) dut_to (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .pwr_req_i   (t_pwr),
        .cfg_valid_i (1'b0),
        .cfg_num_i   (32'd0),
        .cfg_den_i   (32'd0),
        .cfg_ready_o (t_ready),
        .cfg_err_o   (t_err),
        .pll_lock_i  (1'b0),
        .pll_en_o    (t_en),
        .pll_num_o   (t_num),
        .pll_den_o   (t_den),
        .locked_o    (t_locked),
        .lock_lost_o (t_lost),
        .timeout_o   (t_tmo),
        .state_o     (t_st)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
        int n = 0;
        while (st !== s && n < budget) begin
            tick();
            n++;
        end
        ok = (st === s);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pwr = 1'b0; t_pwr = 1'b0; lock = 1'b0;
        cfg_valid = 1'b0; cfg_num = '0; cfg_den = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (st !== 3'd0) begin errors++; $display("FAIL rst_state got %0d want 0", st); end
        checks++; if (pll_en !== 1'b0 || locked !== 1'b0) begin
            errors++; $display("FAIL rst_en_locked got %b%b want 00", pll_en, locked); end
        checks++; if (ready !== 1'b0 || err !== 1'b0 || lost !== 1'b0 || tmo !== 1'b0) begin
            errors++; $display("FAIL rst_flags got %b%b%b%b want 0000", ready, err, lost, tmo); end
        checks++; if (num !== RNum || den !== RDen) begin
            errors++; $display("FAIL rst_ratio got %h/%h want %h/%h", num, den, RNum, RDen); end
        checks++; if (t_num !== 32'h1 || t_den !== 32'h1 || t_st !== 3'd0) begin
            errors++; $display("FAIL rst_default got %h/%h st %0d want 1/1 st 0", t_num, t_den, t_st); end
        checks++; if (t_ready !== 1'b0 || t_err !== 1'b0 || t_en !== 1'b0 || t_tmo !== 1'b0) begin
            errors++; $display("FAIL rst_default_flags got %b%b%b%b want 0000",
                               t_ready, t_err, t_en, t_tmo); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        exp_num = RNum;
        exp_den = RDen;
    endtask

    task automatic test_power_up();
        int n = 0;
        pwr = 1'b1;
        tick();
        checks++; if (pll_en !== 1'b1 || st !== 3'd1 || locked !== 1'b0) begin
            errors++; $display("FAIL pwr_en got en %b st %0d want en 1 st 1", pll_en, st); end
        cfg_valid = 1'b1; cfg_num = 32'h55; cfg_den = 32'h44;
        #1;
        checks++; if (ready !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL lockwait_holdoff got rdy %b err %b want 0 0", ready, err); end
        tick();
        cfg_valid = 1'b0;
        checks++; if (num !== exp_num || den !== exp_den) begin
            errors++; $display("FAIL lockwait_ratio got %h/%h want %h/%h", num, den, exp_num, exp_den); end
        repeat (48) tick();
        lock = 1'b1;
        while (!locked && n < 10) begin
            tick();
            n++;
        end
        checks++; if (locked !== 1'b1 || 50 + n < 52 || 50 + n > 54) begin
            errors++; $display("FAIL lock_time got locked %b at %0d want 1 at 53+-1", locked, 50 + n); end
    endtask

    task automatic test_ratio_change();
        int low = 1;
        int guard = 0;
        bit ok;
        cfg_valid = 1'b1; cfg_num = 32'h19; cfg_den = 32'h6;
        #1;
        checks++; if (ready !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL ratio_accept got rdy %b err %b want 1 0", ready, err); end
        tick();
        cfg_valid = 1'b0;
        checks++; if (st !== 3'd3 || locked !== 1'b0 || pll_en !== 1'b1 || num !== exp_num) begin
            errors++; $display("FAIL gate got st %0d lk %b en %b num %h want 3 0 1 %h",
                               st, locked, pll_en, num, exp_num); end
        tick();
        exp_num = 32'h19;
        exp_den = 32'h6;
        checks++; if (pll_en !== 1'b0 || st !== 3'd4 || num !== exp_num || den !== exp_den) begin
            errors++; $display("FAIL settle_entry got en %b st %0d %h/%h want 0 4 19/6",
                               pll_en, st, num, den); end
        cfg_valid = 1'b1; cfg_num = 32'h77; cfg_den = 32'h77;
        #1;
        checks++; if (ready !== 1'b0) begin
            errors++; $display("FAIL settle_holdoff got rdy %b want 0", ready); end
        while (!pll_en && guard < 20) begin
            tick();
            cfg_valid = 1'b0;
            guard++;
            if (!pll_en) low++;
        end
        checks++; if (low != Settle || pll_en !== 1'b1 || num !== exp_num) begin
            errors++; $display("FAIL settle_len got %0d cycles num %h want %0d num %h",
                               low, num, Settle, exp_num); end
        wait_state(3'd2, 5, ok);
        checks++; if (!ok || locked !== 1'b1) begin
            errors++; $display("FAIL relock got st %0d lk %b want 2 1", st, locked); end
    endtask

    task automatic test_rejected();
        cfg_valid = 1'b1; cfg_num = $urandom | 32'h1; cfg_den = 32'd0;
        #1;
        checks++; if (ready !== 1'b1 || err !== 1'b1) begin
            errors++; $display("FAIL reject_pulse got rdy %b err %b want 1 1", ready, err); end
        tick();
        cfg_valid = 1'b0;
        #1;
        checks++; if (locked !== 1'b1 || st !== 3'd2 || num !== exp_num || den !== exp_den ||
                      err !== 1'b0) begin
            errors++; $display("FAIL reject_hold got lk %b st %0d %h/%h err %b want 1 2 %h/%h 0",
                               locked, st, num, den, err, exp_num, exp_den); end
    endtask

    task automatic test_lock_loss();
        int n = 0;
        bit ok;
        lock = 1'b0;
        while (!lost && n < 6) begin
            tick();
            n++;
        end
        checks++; if (lost !== 1'b1 || n < 2 || n > 3) begin
            errors++; $display("FAIL lost_pulse got %b after %0d want 1 after 2-3", lost, n); end
        checks++; if (locked !== 1'b0 || st !== 3'd1 || pll_en !== 1'b1) begin
            errors++; $display("FAIL lost_state got lk %b st %0d en %b want 0 1 1", locked, st, pll_en); end
        tick();
        checks++; if (lost !== 1'b0) begin
            errors++; $display("FAIL lost_single got %b want 0", lost); end
        lock = 1'b1;
        wait_state(3'd2, 6, ok);
        checks++; if (!ok) begin errors++; $display("FAIL lost_relock got st %0d want 2", st); end
    endtask

    task automatic test_timeout();
        t_pwr = 1'b1;
        repeat (16) tick();
        checks++; if (t_st !== 3'd1 || t_en !== 1'b1) begin
            errors++; $display("FAIL to_wait got st %0d en %b want 1 1", t_st, t_en); end
        tick();
        checks++; if (t_st !== 3'd5 || t_tmo !== 1'b1 || t_en !== 1'b0 || t_locked !== 1'b0) begin
            errors++; $display("FAIL to_fault got st %0d tmo %b en %b want 5 1 0", t_st, t_tmo, t_en); end
        repeat (5) tick();
        checks++; if (t_st !== 3'd5 || t_tmo !== 1'b1 || t_lost !== 1'b0) begin
            errors++; $display("FAIL to_sticky got st %0d tmo %b want 5 1", t_st, t_tmo); end
        t_pwr = 1'b0;
        tick();
        checks++; if (t_st !== 3'd0 || t_tmo !== 1'b0 || t_en !== 1'b0) begin
            errors++; $display("FAIL to_exit got st %0d tmo %b want 0 0", t_st, t_tmo); end
    endtask

    task automatic test_async_reset();
        cfg_valid = 1'b1; cfg_num = 32'h33; cfg_den = 32'h5;
        tick();
        cfg_valid = 1'b0;
        tick();
        checks++; if (st !== 3'd4 || num !== 32'h33) begin
            errors++; $display("FAIL ar_settle got st %0d num %h want 4 33", st, num); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (st !== 3'd0 || pll_en !== 1'b0 || locked !== 1'b0 || num !== RNum ||
                      den !== RDen) begin
            errors++; $display("FAIL ar_values got st %0d en %b lk %b %h/%h want 0 0 0 %h/%h",
                               st, pll_en, locked, num, den, RNum, RDen); end
        checks++; if (ready !== 1'b0 || err !== 1'b0 || lost !== 1'b0 || tmo !== 1'b0) begin
            errors++; $display("FAIL ar_flags got %b%b%b%b want 0000", ready, err, lost, tmo); end
        pwr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        exp_num = RNum;
        exp_den = RDen;
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            bit          ok, bad, go, in_locked;
            logic [31:0] n, d;
            in_locked = 1'($urandom_range(0, 1));
            n = $urandom;
            d = $urandom;
            case ($urandom_range(0, 5))
                0: n = 32'd0;
                1: d = 32'd0;
                default: ;
            endcase
            bad = (n == 32'd0) || (d == 32'd0);
            if (in_locked) begin
                pwr = 1'b1; lock = 1'b1;
                wait_state(3'd2, 12, ok);
                checks++; if (!ok) begin errors++; $display("FAIL rnd_lock got st %0d want 2", st); end
                cfg_valid = 1'b1; cfg_num = n; cfg_den = d;
                #1;
                checks++; if (ready !== 1'b1 || err !== bad) begin
                    errors++; $display("FAIL rnd_l_hs got rdy %b err %b want 1 %b", ready, err, bad); end
                tick();
                cfg_valid = 1'b0;
                if (bad) begin
                    checks++; if (st !== 3'd2 || num !== exp_num || den !== exp_den) begin
                        errors++; $display("FAIL rnd_l_bad got st %0d %h/%h want 2 %h/%h",
                                           st, num, den, exp_num, exp_den); end
                end else begin
                    int low = 1;
                    int guard = 0;
                    exp_num = n;
                    exp_den = d;
                    tick();
                    checks++; if (st !== 3'd4 || num !== exp_num || den !== exp_den) begin
                        errors++; $display("FAIL rnd_l_load got st %0d %h/%h want 4 %h/%h",
                                           st, num, den, exp_num, exp_den); end
                    while (!pll_en && guard < 20) begin
                        tick();
                        guard++;
                        if (!pll_en) low++;
                    end
                    checks++; if (low != Settle) begin
                        errors++; $display("FAIL rnd_settle got %0d want %0d", low, Settle); end
                end
            end else begin
                pwr = 1'b0;
                wait_state(3'd0, 6, ok);
                checks++; if (!ok) begin errors++; $display("FAIL rnd_off got st %0d want 0", st); end
                go = 1'($urandom_range(0, 1));
                cfg_valid = 1'b1; cfg_num = n; cfg_den = d; pwr = go;
                #1;
                checks++; if (ready !== 1'b1 || err !== bad) begin
                    errors++; $display("FAIL rnd_o_hs got rdy %b err %b want 1 %b", ready, err, bad); end
                tick();
                cfg_valid = 1'b0;
                if (!bad) begin
                    exp_num = n;
                    exp_den = d;
                end
                checks++; if (num !== exp_num || den !== exp_den || st !== {2'b00, go}) begin
                    errors++; $display("FAIL rnd_o_upd got st %0d %h/%h want %0d %h/%h",
                                       st, num, den, go, exp_num, exp_den); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_ratio_change();
        test_rejected();
        test_lock_loss();
        test_timeout();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
